// File: rtl/dda_accum_ctrl.sv
// dda_accum_ctrl: accumulator/sequencer feeding the DDA output register.
// Adds a latched increment to the fed-back accumulator once per clock for a
// programmed number of steps, counting steps and carries along the way.
module dda_accum_ctrl #(
  parameter int W         = 6,
  parameter int CNT_W     = 8,
  parameter int OVF_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [W-1:0]         i_inc,
  input  logic [CNT_W-1:0]     i_nsteps,
  input  logic                 i_clr_acc,
  input  logic [W-1:0]         i_fbk,
  output logic [W-1:0]         o_sum,
  output logic                 o_ovf,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [CNT_W-1:0]     o_step_cnt,
  output logic [OVF_CNT_W-1:0] o_ovf_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [W-1:0]           inc_q, inc_d;
  logic [CNT_W-1:0]       nsteps_q, nsteps_d;
  logic [CNT_W-1:0]       step_cnt_q, step_cnt_d;
  logic [OVF_CNT_W-1:0]   ovf_cnt_q, ovf_cnt_d;
  logic [W:0]             add_full;
  logic [W-1:0]           sum_c;
  logic                   ovf_c;

  // Next-state, counter updates and the combinational sum/carry toward the output register.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    state_d    = state_q;
    inc_d      = inc_q;
    nsteps_d   = nsteps_q;
    step_cnt_d = step_cnt_q;
    ovf_cnt_d  = ovf_cnt_q;
    sum_c      = i_fbk;
    ovf_c      = 1'b0;
    add_full   = {1'b0, i_fbk} + {1'b0, inc_q};

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          // Start takes priority over a simultaneous accumulator clear.
          inc_d      = i_inc;
          nsteps_d   = i_nsteps;
          step_cnt_d = '0;
          ovf_cnt_d  = '0;
          state_d    = (i_nsteps == '0) ? DONE : RUN;
        end else if (i_clr_acc) begin
          sum_c = '0;
        end
      end
      RUN: begin
        sum_c      = add_full[W-1:0];
        ovf_c      = add_full[W];
        step_cnt_d = step_cnt_q + CNT_W'(1);
        if (add_full[W] && (ovf_cnt_q != '1)) begin
          ovf_cnt_d = ovf_cnt_q + OVF_CNT_W'(1);
        end
        // nsteps_q is non-zero whenever RUN is entered, so the subtraction never wraps.
        if (step_cnt_q == nsteps_q - CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Register FSM state, latched run parameters and counters; synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (i_rst) begin
      state_q    <= IDLE;
      inc_q      <= '0;
      nsteps_q   <= '0;
      step_cnt_q <= '0;
      ovf_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      inc_q      <= inc_d;
      nsteps_q   <= nsteps_d;
      step_cnt_q <= step_cnt_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  // Outputs are forced quiet while reset is asserted so the output register clears too.
  always_comb begin
    o_sum      = i_rst ? '0 : sum_c;
    o_ovf      = i_rst ? 1'b0 : ovf_c;
    o_busy     = !i_rst && (state_q == RUN);
    o_done     = !i_rst && (state_q == DONE);
    o_step_cnt = step_cnt_q;
    o_ovf_cnt  = ovf_cnt_q;
  end

endmodule
